// File: rtl/ap_mult_pkg.sv
// Shared types and constants for the ap_unsi_wall_12b_* multipliers.
// PPGEN_EXACT_EN adds the exact-product field to the pp_gen buffer entry.
package ap_mult_pkg;

    localparam int AP_W     = 12;
    localparam int AP_PP_W  = AP_W * AP_W;
    localparam int AP_TAG_W = 4;

    typedef enum logic [1:0] {
        PPGEN_EMPTY = 2'd0,
        PPGEN_ONE   = 2'd1,
        PPGEN_FULL  = 2'd2
    } ppgen_state_e;

    typedef struct packed {
`ifdef PPGEN_EXACT_EN
        logic [2*AP_W-1:0]   exact;
`endif
        logic [AP_TAG_W-1:0] tag;
        logic [AP_PP_W-1:0]  pp;
    } ppgen_entry_t;

endpackage

// File: rtl/pp_gen_if.sv
// Operand-in / partial-product-out bus of pp_gen. out_exact exists only with PPGEN_EXACT_EN.
// Handshake: a beat moves on a rising edge where valid & ready; the sender holds it until then.
interface pp_gen_if #(
    parameter int W     = 12,
    parameter int TAG_W = 4
) ();

    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_a;
    logic [W-1:0]       in_b;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [W*W-1:0]     out_pp;
    logic [TAG_W-1:0]   out_tag;
    logic [15:0]        out_cnt;
`ifdef PPGEN_EXACT_EN
    logic [2*W-1:0]     out_exact;
`endif

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_pp, out_tag, out_cnt
`ifdef PPGEN_EXACT_EN
        , input out_exact
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_pp, out_tag, out_cnt
`ifdef PPGEN_EXACT_EN
        , output out_exact
`endif
    );

endinterface

// File: rtl/pp_and_array.sv
// Combinational W x W AND array, row-major: pp[W*i+j] = a[j] & b[i].
module pp_and_array #(
    parameter int W = 12
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W*W-1:0] pp
);

    for (genvar i = 0; i < W; i++) begin : g_row
        for (genvar j = 0; j < W; j++) begin : g_col
            assign pp[W*i+j] = a[j] & b[i];
        end
    end

endmodule

// File: rtl/pp_gen.sv
// Partial-product generator with a two-entry skid buffer on the output side.
// PPGEN_EXACT_EN adds an exact a*b product that travels with each beat.
module pp_gen
    import ap_mult_pkg::*;
#(
    parameter int W     = AP_W,
    parameter int TAG_W = AP_TAG_W
) (
    input  logic       clk,
    input  logic       rst_n,
    pp_gen_if.slave    bus,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] ST_EMPTY = PPGEN_EMPTY;
    localparam logic [1:0] ST_ONE   = PPGEN_ONE;
    localparam logic [1:0] ST_FULL  = PPGEN_FULL;

    logic [1:0]     state_q, state_nxt;
    logic           in_ready_q;
    logic [15:0]    cnt_q;
    ppgen_entry_t   main_q, skid_q, new_e;
    logic [W*W-1:0] pp_new;
    logic           in_hs, out_hs;
    logic           main_ld, main_from_skid, skid_ld;

    pp_and_array #(.W(W)) u_and_array (
        .a  (bus.in_a),
        .b  (bus.in_b),
        .pp (pp_new)
    );

    always_comb begin
        new_e     = '0;
        new_e.pp  = pp_new;
        new_e.tag = bus.in_tag;
`ifdef PPGEN_EXACT_EN
        new_e.exact = {{W{1'b0}}, bus.in_a} * {{W{1'b0}}, bus.in_b};
`endif
    end

    assign in_hs  = bus.in_valid & in_ready_q;
    assign out_hs = (state_q != ST_EMPTY) & bus.out_ready;

    // FULL never sees in_hs because in_ready is low there.
    always_comb begin
        state_nxt      = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_hs) begin
                    state_nxt = ST_ONE;
                    main_ld   = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_hs && out_hs) begin
                    main_ld = 1'b1;
                end else if (in_hs) begin
                    state_nxt = ST_FULL;
                    skid_ld   = 1'b1;
                end else if (out_hs) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_hs) begin
                    state_nxt      = ST_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_nxt;
            in_ready_q <= (state_nxt != ST_FULL);
            if (main_ld) begin
                main_q <= new_e;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (skid_ld) begin
                skid_q <= new_e;
            end
            if (out_hs) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_pp    = main_q.pp;
    assign bus.out_tag   = main_q.tag;
    assign bus.out_cnt   = cnt_q;
`ifdef PPGEN_EXACT_EN
    assign bus.out_exact = main_q.exact;
`endif
    assign dbg_state     = state_q;

endmodule
